stack_unit: RTL and testbench
=============================

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 64: stack capacity in 16-bit words, power of two, at least 4.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port op_valid, input, 1: operation request.
REQ-005 SHALL have port op_push, input, 1: 1 = push, 0 = pop; sampled at acceptance.
REQ-006 SHALL have port op_wide, input, 1: 1 = 32-bit (two words), 0 = 16-bit; sampled at acceptance.
REQ-007 SHALL have port data_in, input, 32: push data; narrow uses [15:0]; sampled at acceptance.
REQ-008 SHALL have port op_ready, output, 1: high only in IDLE.
REQ-009 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port data_out, output, 32: pop result, valid while done is high.
REQ-011 SHALL have port err, output, 1: guard violation, valid while done is high.
REQ-012 SHALL have port sp, output, 32: byte stack pointer; top-of-stack word is at sp/2.
REQ-013 SHALL have ports full and empty, output, 1 each: full = (sp==0); empty = (sp==2*DEPTH).

Function
REQ-014 SHALL implement FSM states IDLE, W1, W2, DONE: IDLE->W1 on acceptance; W1->W2 if wide, else W1->DONE; W2->DONE; DONE->IDLE unconditionally.
REQ-015 SHALL accept an operation in a cycle where op_valid and op_ready are both high; op_valid outside IDLE is ignored.
REQ-016 SHALL, per pushed word: write mem[(sp/2-1) mod DEPTH] = word, then sp -= 2, in the same cycle.
REQ-017 SHALL, per popped word: read mem[(sp/2) mod DEPTH], then sp += 2, in the same cycle.
REQ-018 SHALL push wide data as data_in[31:16] in W1 and data_in[15:0] in W2; the low half ends on top.
REQ-019 SHALL pop wide data as the low half in W1 and the high half in W2; data_out = {high, low}.
REQ-020 SHALL set data_out = {16'h0, word} for a narrow pop, and leave data_out unchanged after a push.
REQ-021 SHALL assert done in DONE only, giving latency from acceptance cycle T: narrow done at T+2, wide done at T+3.
REQ-022 SHALL keep err low in all states except DONE.
REQ-023 SHALL allow a new acceptance no earlier than the cycle after done.
REQ-024 SHALL drive sp combinationally from the register, so push/pop changes are visible the cycle after each word step.

Reset
REQ-025 SHALL, while rst is low: set state = IDLE, sp = 2*DEPTH, done = 0, err = 0, data_out = 0.
REQ-026 SHALL leave memory contents unreset.
REQ-027 SHALL, on reset mid-operation, abort the operation with no done pulse; words already written remain in memory.

Configuration
REQ-028 SHALL, with STACK_GUARD_EN defined, check bounds at acceptance using these rules:
- push needs sp >= 2 (narrow) or sp >= 4 (wide).
- pop needs sp <= 2*DEPTH-2 (narrow) or sp <= 2*DEPTH-4 (wide).
- on violation: go IDLE->DONE directly, change neither memory nor sp, set data_out = 0, and assert err with done (done at T+1).
REQ-029 SHALL, without STACK_GUARD_EN, perform no bounds checks:
- tie err to 0.
- sp wraps modulo 2^32.
- memory index wraps modulo DEPTH.

Verification (DEPTH=64)
REQ-030 SHALL check reset: rst low -> sp=128, empty=1, full=0, op_ready=1, done=0.
REQ-031 SHALL check narrow push 0x1234 at T, then narrow pop: push done at T+2 with sp=126; pop done with data_out=0x00001234 and sp=128.
REQ-032 SHALL check wide push 0xDEADBEEF, then wide pop: push done at T+3 with sp=124; pop returns 0xDEADBEEF with sp=128. Also check that wide push followed by narrow pop returns 0x0000BEEF.
REQ-033 SHALL check 64 narrow pushes -> sp=0 and full=1. A 65th push then gives: with STACK_GUARD_EN, err=1 at T+1 and sp stays 0; without it, err=0 and sp=0xFFFFFFFE.
REQ-034 SHALL check, with STACK_GUARD_EN, narrow pop on empty -> done with err=1, data_out=0, sp=128, and a repeat of REQ-033's 65th-push case using a wide push at sp=2 -> err=1.
REQ-035 SHALL check rst pulsed low during W2 of a wide push -> sp=128, state IDLE, no done pulse, op_ready=1 after release.

Source files
------------

// File: rtl/stack_unit.sv
// stack_unit: 16-bit word LIFO with narrow/wide push/pop FSM; define STACK_GUARD_EN for bounds checking
module stack_unit #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic        op_push,
    input  logic        op_wide,
    input  logic [31:0] data_in,
    output logic        op_ready,
    output logic        done,
    output logic [31:0] data_out,
    output logic        err,
    output logic [31:0] sp,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] SP_TOP = 32'(2 * DEPTH);

    typedef enum logic [1:0] {IDLE, W1, W2, DONE} state_t;

    state_t      state;
    logic        push_q;
    logic        wide_q;
    logic [31:0] data_q;
    logic [15:0] lo_q;
    logic [31:0] sp_q;
    logic [15:0] mem [DEPTH];
    logic        accept;
    logic        viol;
    logic        step;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic [15:0] rd_word;
    logic [15:0] wr_word;

    assign accept   = op_valid && (state == IDLE);
    assign step     = (state == W1) || (state == W2);
    assign rd_idx   = sp_q[AW:1];
    assign wr_idx   = rd_idx - AW'(1);
    assign rd_word  = mem[rd_idx];
    assign wr_word  = (state == W1 && wide_q) ? data_q[31:16] : data_q[15:0];
    assign op_ready = (state == IDLE);
    assign sp       = sp_q;
    assign full     = (sp_q == 32'd0);
    assign empty    = (sp_q == SP_TOP);

`ifdef STACK_GUARD_EN
    assign viol = op_push ? (sp_q < (op_wide ? 32'd4 : 32'd2))
                          : (sp_q > (op_wide ? SP_TOP - 32'd4 : SP_TOP - 32'd2));
`else
    assign viol = 1'b0;
`endif

    // Word storage is left unreset; writes happen only in word-step states.
    always_ff @(posedge clk) begin
        if (step && push_q) mem[wr_idx] <= wr_word;
    end

    // Operation sequencer: one word step per W state, guard violations skip straight to DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sp_q     <= SP_TOP;
            done     <= 1'b0;
            err      <= 1'b0;
            data_out <= 32'd0;
            push_q   <= 1'b0;
            wide_q   <= 1'b0;
            data_q   <= 32'd0;
            lo_q     <= 16'd0;
        end else begin
            err  <= accept && viol;
            done <= (accept && viol) || (state == W1 && !wide_q) || (state == W2);
            if (step) sp_q <= push_q ? sp_q - 32'd2 : sp_q + 32'd2;
            case (state)
                IDLE: if (op_valid) begin
                    push_q <= op_push;
                    wide_q <= op_wide;
                    data_q <= data_in;
                    state  <= viol ? DONE : W1;
                    if (viol) data_out <= 32'd0;
                end
                W1: begin
                    state <= wide_q ? W2 : DONE;
                    if (!push_q && wide_q) lo_q <= rd_word;
                    if (!push_q && !wide_q) data_out <= {16'h0, rd_word};
                end
                W2: begin
                    state <= DONE;
                    if (!push_q) data_out <= {rd_word, lo_q};
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: randomized self-checking bench for stack_unit against a word-stack reference model
module tb_stack_unit;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_push = 1'b0;
    logic        op_wide = 1'b0;
    logic [31:0] data_in = 32'd0;
    logic        op_ready;
    logic        done;
    logic [31:0] data_out;
    logic        err;
    logic [31:0] sp;
    logic        full;
    logic        empty;

    int checks = 0;
    int passed = 0;

    logic [15:0] m_mem [DEPTH];
    logic [31:0] m_sp = 32'd128;
    logic [31:0] m_dout = 32'd0;

    stack_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_push(op_push), .op_wide(op_wide),
        .data_in(data_in), .op_ready(op_ready), .done(done), .data_out(data_out),
        .err(err), .sp(sp), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic push_w(input logic [15:0] w);
        m_sp = m_sp - 32'd2;
        m_mem[(m_sp / 2) % DEPTH] = w;
    endtask

    task automatic pop_w(output logic [15:0] w);
        w = m_mem[(m_sp / 2) % DEPTH];
        m_sp = m_sp + 32'd2;
    endtask

    task automatic model(input bit push, input bit wide, input logic [31:0] d,
                         output int lat, output logic [31:0] e_dout, output logic e_err);
        bit v = 1'b0;
        logic [15:0] lo, hi;
`ifdef STACK_GUARD_EN
        v = push ? (m_sp < (wide ? 4 : 2)) : (m_sp > 2 * DEPTH - (wide ? 4 : 2));
`endif
        e_err = v;
        if (v) begin
            lat = 1;
            m_dout = 32'd0;
        end else begin
            lat = wide ? 3 : 2;
            if (push) begin
                if (wide) push_w(d[31:16]);
                push_w(d[15:0]);
            end else if (wide) begin
                pop_w(lo);
                pop_w(hi);
                m_dout = {hi, lo};
            end else begin
                pop_w(lo);
                m_dout = {16'h0, lo};
            end
        end
        e_dout = m_dout;
    endtask

    task automatic run_op(input bit push, input bit wide, input logic [31:0] d,
                          output int lat, output logic [31:0] o_dout, output logic o_err,
                          output logic [31:0] o_sp);
        @(negedge clk);
        op_valid = 1'b1; op_push = push; op_wide = wide; data_in = d;
        @(posedge clk);
        #1 op_valid = 1'b0; op_push = 1'($urandom); op_wide = 1'($urandom); data_in = $urandom;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        o_dout = data_out; o_err = err; o_sp = sp;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (sp !== 32'd128) $display("FAIL reset_sp got %h want %h", sp, 32'd128); else passed++;
        checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else passed++;
        checks++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else passed++;
        checks++; if (op_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", op_ready); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else passed++;
        checks++; if (data_out !== 32'd0) $display("FAIL reset_dout got %h want 0", data_out); else passed++;
        rst = 1'b1;
        m_sp = 32'd128; m_dout = 32'd0;
    endtask

    task automatic test_narrow();
        int lat, e_lat; logic [31:0] o_dout, o_sp, e_dout; logic o_err, e_err;
        model(1, 0, 32'h0000_1234, e_lat, e_dout, e_err);
        run_op(1, 0, 32'h0000_1234, lat, o_dout, o_err, o_sp);
        checks++; if (lat !== 2 || o_sp !== 32'd126) $display("FAIL narrow_push lat=%0d sp=%h want lat=2 sp=7e", lat, o_sp); else passed++;
        model(0, 0, 32'h0, e_lat, e_dout, e_err);
        run_op(0, 0, 32'hFFFF_FFFF, lat, o_dout, o_err, o_sp);
        checks++; if (lat !== 2 || o_dout !== 32'h0000_1234 || o_sp !== 32'd128)
            $display("FAIL narrow_pop lat=%0d dout=%h sp=%h want 2 00001234 80", lat, o_dout, o_sp); else passed++;
    endtask

    task automatic test_wide();
        int lat, e_lat; logic [31:0] o_dout, o_sp, e_dout; logic o_err, e_err;
        model(1, 1, 32'hDEAD_BEEF, e_lat, e_dout, e_err);
        run_op(1, 1, 32'hDEAD_BEEF, lat, o_dout, o_err, o_sp);
        checks++; if (lat !== 3 || o_sp !== 32'd124 || o_dout !== 32'h0000_1234)
            $display("FAIL wide_push lat=%0d sp=%h dout=%h want 3 7c 00001234", lat, o_sp, o_dout); else passed++;
        model(0, 1, 32'h0, e_lat, e_dout, e_err);
        run_op(0, 1, 32'h0, lat, o_dout, o_err, o_sp);
        checks++; if (lat !== 3 || o_dout !== 32'hDEAD_BEEF || o_sp !== 32'd128)
            $display("FAIL wide_pop lat=%0d dout=%h sp=%h want 3 deadbeef 80", lat, o_dout, o_sp); else passed++;
        model(1, 1, 32'hDEAD_BEEF, e_lat, e_dout, e_err);
        run_op(1, 1, 32'hDEAD_BEEF, lat, o_dout, o_err, o_sp);
        model(0, 0, 32'h0, e_lat, e_dout, e_err);
        run_op(0, 0, 32'h0, lat, o_dout, o_err, o_sp);
        checks++; if (o_dout !== 32'h0000_BEEF || o_sp !== 32'd126)
            $display("FAIL wide_narrow_lo dout=%h sp=%h want 0000beef 7e", o_dout, o_sp); else passed++;
        model(0, 0, 32'h0, e_lat, e_dout, e_err);
        run_op(0, 0, 32'h0, lat, o_dout, o_err, o_sp);
        checks++; if (o_dout !== 32'h0000_DEAD || o_sp !== 32'd128)
            $display("FAIL wide_narrow_hi dout=%h sp=%h want 0000dead 80", o_dout, o_sp); else passed++;
    endtask

    task automatic test_fill();
        int lat, e_lat; logic [31:0] o_dout, o_sp, e_dout, d; logic o_err, e_err;
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            model(1, 0, d, e_lat, e_dout, e_err);
            run_op(1, 0, d, lat, o_dout, o_err, o_sp);
        end
        checks++; if (sp !== 32'd0 || full !== 1'b1 || empty !== 1'b0)
            $display("FAIL fill sp=%h full=%b empty=%b want 0 1 0", sp, full, empty); else passed++;
        d = 32'h0000_7777;
        model(1, 0, d, e_lat, e_dout, e_err);
        run_op(1, 0, d, lat, o_dout, o_err, o_sp);
`ifdef STACK_GUARD_EN
        checks++; if (lat !== 1 || o_err !== 1'b1 || o_sp !== 32'd0)
            $display("FAIL overflow lat=%0d err=%b sp=%h want 1 1 0", lat, o_err, o_sp); else passed++;
`else
        checks++; if (lat !== 2 || o_err !== 1'b0 || o_sp !== 32'hFFFF_FFFE)
            $display("FAIL overflow lat=%0d err=%b sp=%h want 2 0 fffffffe", lat, o_err, o_sp); else passed++;
`endif
        while (m_sp != 32'd128) begin
            model(0, 0, 32'h0, e_lat, e_dout, e_err);
            run_op(0, 0, 32'h0, lat, o_dout, o_err, o_sp);
            checks++; if (o_dout !== e_dout || o_sp !== m_sp || lat !== e_lat)
                $display("FAIL drain dout=%h sp=%h lat=%0d want %h %h %0d", o_dout, o_sp, lat, e_dout, m_sp, e_lat); else passed++;
        end
    endtask

    task automatic test_guard();
`ifdef STACK_GUARD_EN
        int lat, e_lat; logic [31:0] o_dout, o_sp, e_dout; logic o_err, e_err;
        model(0, 0, 32'h0, e_lat, e_dout, e_err);
        run_op(0, 0, 32'h0, lat, o_dout, o_err, o_sp);
        checks++; if (lat !== 1 || o_err !== 1'b1 || o_dout !== 32'd0 || o_sp !== 32'd128)
            $display("FAIL pop_empty lat=%0d err=%b dout=%h sp=%h want 1 1 0 80", lat, o_err, o_dout, o_sp); else passed++;
        model(1, 0, 32'h0000_4321, e_lat, e_dout, e_err);
        run_op(1, 0, 32'h0000_4321, lat, o_dout, o_err, o_sp);
        model(0, 1, 32'h0, e_lat, e_dout, e_err);
        run_op(0, 1, 32'h0, lat, o_dout, o_err, o_sp);
        checks++; if (lat !== 1 || o_err !== 1'b1 || o_dout !== 32'd0 || o_sp !== 32'd126)
            $display("FAIL wide_pop_one lat=%0d err=%b dout=%h sp=%h want 1 1 0 7e", lat, o_err, o_dout, o_sp); else passed++;
        model(0, 0, 32'h0, e_lat, e_dout, e_err);
        run_op(0, 0, 32'h0, lat, o_dout, o_err, o_sp);
        checks++; if (o_err !== 1'b0 || o_dout !== 32'h0000_4321)
            $display("FAIL pop_after_err err=%b dout=%h want 0 00004321", o_err, o_dout); else passed++;
        for (int i = 0; i < DEPTH - 1; i++) begin
            model(1, 0, 32'(i), e_lat, e_dout, e_err);
            run_op(1, 0, 32'(i), lat, o_dout, o_err, o_sp);
        end
        model(1, 1, 32'hA5A5_5A5A, e_lat, e_dout, e_err);
        run_op(1, 1, 32'hA5A5_5A5A, lat, o_dout, o_err, o_sp);
        checks++; if (lat !== 1 || o_err !== 1'b1 || o_sp !== 32'd2)
            $display("FAIL wide_push_sp2 lat=%0d err=%b sp=%h want 1 1 2", lat, o_err, o_sp); else passed++;
        while (m_sp != 32'd128) begin
            model(0, 0, 32'h0, e_lat, e_dout, e_err);
            run_op(0, 0, 32'h0, lat, o_dout, o_err, o_sp);
            checks++; if (o_dout !== e_dout || o_err !== 1'b0)
                $display("FAIL guard_drain dout=%h err=%b want %h 0", o_dout, o_err, e_dout); else passed++;
        end
`endif
    endtask

    task automatic test_back_to_back();
        int dones = 0, lat, e_lat; logic [31:0] o_dout, o_sp, e_dout; logic o_err, e_err;
        @(negedge clk);
        op_valid = 1'b1; op_push = 1'b1; op_wide = 1'b0; data_in = 32'h0000_5A5A;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        op_valid = 1'b0;
        repeat (4) model(1, 0, 32'h0000_5A5A, e_lat, e_dout, e_err);
        checks++; if (dones !== 4 || sp !== m_sp)
            $display("FAIL back_to_back dones=%0d sp=%h want 4 %h", dones, sp, m_sp); else passed++;
        repeat (4) begin
            model(0, 0, 32'h0, e_lat, e_dout, e_err);
            run_op(0, 0, 32'h0, lat, o_dout, o_err, o_sp);
            checks++; if (o_dout !== 32'h0000_5A5A || o_sp !== m_sp)
                $display("FAIL b2b_pop dout=%h sp=%h want 00005a5a %h", o_dout, o_sp, m_sp); else passed++;
        end
    endtask

    task automatic test_random();
        int lat, e_lat; logic [31:0] o_dout, o_sp, e_dout, d; logic o_err, e_err; bit push, wide;
        for (int i = 0; i < 300; i++) begin
            wide = 1'($urandom);
            push = (m_sp < 32'd4) ? 1'b0 : (m_sp > 32'd124) ? 1'b1 : 1'($urandom);
            d = $urandom;
            model(push, wide, d, e_lat, e_dout, e_err);
            run_op(push, wide, d, lat, o_dout, o_err, o_sp);
            checks++; if (lat !== e_lat || o_err !== e_err)
                $display("FAIL rand_lat op%0d lat=%0d err=%b want %0d %b", i, lat, o_err, e_lat, e_err); else passed++;
            checks++; if (o_dout !== e_dout)
                $display("FAIL rand_dout op%0d got %h want %h", i, o_dout, e_dout); else passed++;
            checks++; if (o_sp !== m_sp || full !== (m_sp == 0) || empty !== (m_sp == 128))
                $display("FAIL rand_sp op%0d sp=%h full=%b empty=%b want sp %h", i, o_sp, full, empty, m_sp); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        @(negedge clk);
        op_valid = 1'b1; op_push = 1'b1; op_wide = 1'b1; data_in = 32'hCAFE_F00D;
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done) dones++;
        end
        m_mem[63] = 16'hCAFE; m_sp = 32'd128; m_dout = 32'd0;
        checks++; if (dones !== 0) $display("FAIL midreset_done got %0d pulses want 0", dones); else passed++;
        checks++; if (sp !== 32'd128 || op_ready !== 1'b1 || err !== 1'b0 || data_out !== 32'd0)
            $display("FAIL midreset_state sp=%h ready=%b err=%b dout=%h want 80 1 0 0", sp, op_ready, err, data_out); else passed++;
    endtask

    initial begin
        test_reset();
        test_narrow();
        test_wide();
        test_fill();
        test_guard();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
